// File: rtl/ov7670_cfg_pkg.sv
// rtl/ov7670_cfg_pkg.sv - shared types and constants for the OV7670 configuration sequencer
package ov7670_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWRUP_WAIT,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_DONE,
    DELAY,
    DONE,
    ERROR
  } cfg_state_t;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [7:0]  DELAY_ADDR = 8'hFF;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/ov7670_cfg_rom.sv
// rtl/ov7670_cfg_rom.sv - OV7670 register table; {addr, data} per entry, FFnn = nn ms delay, FFFF = end
module ov7670_cfg_rom
  import ov7670_cfg_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic [IDX_W-1:0] idx,
  output cfg_entry_t       entry
);

  always_comb begin
    entry = END_MARK;
    case (idx)
      IDX_W'(0): entry = 16'h1280;  // COM7 soft reset
      IDX_W'(1): entry = 16'hFF0A;  // let the sensor settle after reset
      IDX_W'(2): entry = 16'h1204;  // COM7 RGB output
      IDX_W'(3): entry = 16'hFF00;
      IDX_W'(4): entry = 16'h1100;  // CLKRC no prescale
      IDX_W'(5): entry = END_MARK;
      default:   entry = END_MARK;
    endcase
  end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// rtl/ov7670_cfg_sequencer.sv - walks the OV7670 register table and feeds the SCCB write engine
// Optional: define CFG_RETRY_EN to re-issue NACKed writes up to MAX_RETRY times.
module ov7670_cfg_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int TICKS_PER_MS   = 100000,
  parameter int PWRUP_DELAY_MS = 2,
  parameter int ROM_DEPTH      = 128,
  parameter int IDX_W          = 7,
  parameter int MAX_RETRY      = 3,
  parameter int AUTO_START     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             sccb_req,
  output logic [7:0]       sccb_reg_addr,
  output logic [7:0]       sccb_reg_data,
  input  logic             sccb_ack,
  input  logic             sccb_done,
  input  logic             sccb_nack,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_error,
  output logic [IDX_W-1:0] cfg_index
);

  localparam int               CNT_W       = $clog2(255 * TICKS_PER_MS + 1);
  localparam logic [CNT_W-1:0] TICKS       = CNT_W'(TICKS_PER_MS);
  localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_DELAY_MS * TICKS_PER_MS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ROM_DEPTH - 1);
  localparam cfg_state_t       RESET_STATE = (AUTO_START != 0) ? PWRUP_WAIT : IDLE;

  cfg_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  cfg_entry_t       entry_q, rom_entry;
  logic [7:0]       addr_q, addr_d, data_q, data_d;
  logic             req_d, busy_d, done_d, err_d;
  logic             advance, write_end;
  logic [CNT_W-1:0] delay_ticks;

`ifdef CFG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  ov7670_cfg_rom #(.IDX_W(IDX_W)) u_rom (
    .idx   (idx_q),
    .entry (rom_entry)
  );

  assign delay_ticks = CNT_W'(entry_q.data) * TICKS;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    advance   = 1'b0;
    write_end = 1'b0;
`ifdef CFG_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PWRUP_WAIT;
          cnt_d   = '0;
        end
      end
      PWRUP_WAIT: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (entry_q == END_MARK) begin
          state_d = DONE;
        end else if (entry_q.addr == DELAY_ADDR) begin
          if (entry_q.data == 8'h00) begin
            advance = 1'b1;
          end else begin
            cnt_d   = delay_ticks - CNT_W'(1);
            state_d = DELAY;
          end
        end else begin
          addr_d  = entry_q.addr;
          data_d  = entry_q.data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // an engine that finishes in the same cycle it accepts skips WAIT_DONE
        if (sccb_ack) begin
          if (sccb_done) write_end = 1'b1;
          else           state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (sccb_done) write_end = 1'b1;
      end
      DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        if (start) begin
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      ERROR: begin
        if (start) begin
          idx_d   = '0;
`ifdef CFG_RETRY_EN
          retry_d = '0;
`endif
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (write_end) begin
      if (!sccb_nack) begin
        advance = 1'b1;
`ifdef CFG_RETRY_EN
        retry_d = '0;
`endif
      end else begin
`ifdef CFG_RETRY_EN
        if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = ISSUE;
        end else begin
          state_d = ERROR;
        end
`else
        state_d = ERROR;
`endif
      end
    end

    // the last table slot finishes the run instead of wrapping the index
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = FETCH;
      end
    end

    req_d  = (state_d == ISSUE);
    busy_d = state_d inside {PWRUP_WAIT, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY};
    done_d = (state_d == DONE);
    err_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      idx_q     <= '0;
      entry_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      sccb_req  <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      if (state_q == FETCH) entry_q <= rom_entry;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sccb_req  <= req_d;
      cfg_busy  <= busy_d;
      cfg_done  <= done_d;
      cfg_error <= err_d;
    end
  end

`ifdef CFG_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`endif

  assign sccb_reg_addr = addr_q;
  assign sccb_reg_data = data_q;
  assign cfg_index     = idx_q;

endmodule
